// File: rtl/rscpu_pkg.sv
// Shared types for the 8-bit accumulator CPU: FSM states, opcodes, AC source encodings.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a; is_mem_state() names the states that stall on mem_ready.
package rscpu_pkg;

  typedef enum logic [4:0] {
    FETCH1, FETCH2, FETCH3,
    NOP1,
    LDAC1, LDAC2, LDAC3, LDAC4, LDAC5,
    STAC1, STAC2, STAC3, STAC4, STAC5,
    MVAC1, MOVR1,
    JUMP1, JUMP2, JUMP3,
    ALU1,
    SKIP1, SKIP2,
    HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDAC = 4'h1;
  localparam logic [3:0] OP_STAC = 4'h2;
  localparam logic [3:0] OP_MVAC = 4'h3;
  localparam logic [3:0] OP_MOVR = 4'h4;
  localparam logic [3:0] OP_JUMP = 4'h5;
  localparam logic [3:0] OP_JMPZ = 4'h6;
  localparam logic [3:0] OP_JPNZ = 4'h7;

  typedef logic [1:0] ac_sel_t;
  localparam ac_sel_t AC_SRC_DR  = 2'd0;
  localparam ac_sel_t AC_SRC_R   = 2'd1;
  localparam ac_sel_t AC_SRC_ALU = 2'd2;

  // States that hold a memory request until mem_ready.
  function automatic logic is_mem_state(input state_t s);
    case (s)
      FETCH2, LDAC1, LDAC2, LDAC4, STAC1, STAC2, STAC5, JUMP1, JUMP2: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rscpu_control_unit_if.sv
// Control-unit <-> datapath/memory bundle: decode inputs, register strobes, mem request.
// Latency: n/a (wires only).
// Backpressure: mem_ready from the memory side stalls the control unit.
// Ports: ir, z, mem_ready into the control unit; strobes, selects, mem_rd/mem_wr, mem_err out.
interface rscpu_control_unit_if;
  import rscpu_pkg::*;

  logic [7:0] ir;
  logic       z;
  logic       mem_ready;

  logic       ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, tr_ld, ir_ld, r_ld, ac_ld, z_ld;
  logic       ar_sel;
  logic       dr_sel;
  ac_sel_t    ac_sel;
  logic [2:0] alu_sel;
  logic       mem_rd, mem_wr, mem_err;

  modport master (
    input  ir, z, mem_ready,
    output ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, tr_ld, ir_ld, r_ld, ac_ld, z_ld,
    output ar_sel, dr_sel, ac_sel, alu_sel, mem_rd, mem_wr, mem_err
  );

  modport slave (
    output ir, z, mem_ready,
    input  ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, tr_ld, ir_ld, r_ld, ac_ld, z_ld,
    input  ar_sel, dr_sel, ac_sel, alu_sel, mem_rd, mem_wr, mem_err
  );

endinterface

// File: rtl/rscpu_mem_wait.sv
// Memory wait timeout counter: counts stalled cycles of one memory access.
// Latency: expired is combinational in the stalled cycle that would reach MEM_TIMEOUT.
// Backpressure: none; MEM_TIMEOUT=0 disables expiry (wait forever).
// Ports: clk, reset (async, active-high), clear (restart), count (stalled this cycle), expired.
module rscpu_mem_wait #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  // Counter only ever holds 0..MEM_TIMEOUT-1; the stall that would reach the limit expires instead.
  localparam int unsigned CW    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam int unsigned LIMIT = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
  localparam bit          ENA   = (MEM_TIMEOUT != 0);

  logic [CW-1:0] cnt;

  assign expired = ENA && count && (cnt == CW'(LIMIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (ENA && count && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/rscpu_control_unit.sv
// Hardwired fetch/decode/execute FSM for the 8-bit accumulator CPU.
// Latency: 4 cycles NOP/MVAC/MOVR/ALU, 5 not-taken branch, 6 JUMP/taken branch, 8 LDAC/STAC (zero wait).
// Backpressure: memory states hold mem_rd/mem_wr until mem_ready; a stuck access halts the core.
// Ports: clk, reset (async, active-high), bus (master side of rscpu_control_unit_if).
// Decode happens in FETCH3, so the datapath must present the fetched opcode on ir in that cycle.
module rscpu_control_unit
  import rscpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  rscpu_control_unit_if.master bus
);

  state_t state_q, state_d;
  logic   waiting;
  logic   tmo_expired;

  assign waiting = is_mem_state(state_q) && !bus.mem_ready;

  rscpu_mem_wait #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait (
    .clk    (clk),
    .reset  (reset),
    .clear  (!waiting),
    .count  (waiting),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH1;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    bus.ar_ld   = 1'b0;
    bus.ar_inc  = 1'b0;
    bus.pc_ld   = 1'b0;
    bus.pc_inc  = 1'b0;
    bus.dr_ld   = 1'b0;
    bus.tr_ld   = 1'b0;
    bus.ir_ld   = 1'b0;
    bus.r_ld    = 1'b0;
    bus.ac_ld   = 1'b0;
    bus.z_ld    = 1'b0;
    bus.ar_sel  = 1'b0;
    bus.dr_sel  = 1'b0;
    bus.ac_sel  = AC_SRC_DR;
    bus.alu_sel = 3'b000;
    bus.mem_rd  = 1'b0;
    bus.mem_wr  = 1'b0;
    bus.mem_err = 1'b0;

    // Outputs are forced low while reset is held so nothing fires after reset asserts.
    if (!reset) begin
      case (state_q)
        FETCH1: begin
          bus.ar_ld = 1'b1;
          state_d   = FETCH2;
        end
        FETCH2: begin
          bus.mem_rd = 1'b1;
          if (bus.mem_ready) begin
            bus.dr_ld  = 1'b1;
            bus.pc_inc = 1'b1;
            state_d    = FETCH3;
          end
        end
        FETCH3: begin
          bus.ir_ld = 1'b1;
          bus.ar_ld = 1'b1;
          if (bus.ir[7:4] != 4'h0) begin
            state_d = NOP1;
          end else if (bus.ir[3]) begin
            state_d = ALU1;
          end else begin
            case (bus.ir[3:0])
              OP_LDAC: state_d = LDAC1;
              OP_STAC: state_d = STAC1;
              OP_MVAC: state_d = MVAC1;
              OP_MOVR: state_d = MOVR1;
              OP_JUMP: state_d = JUMP1;
              OP_JMPZ: state_d = bus.z  ? JUMP1 : SKIP1;
              OP_JPNZ: state_d = !bus.z ? JUMP1 : SKIP1;
              default: state_d = NOP1;
            endcase
          end
        end
        NOP1: state_d = FETCH1;
        LDAC1, STAC1: begin
          bus.mem_rd = 1'b1;
          if (bus.mem_ready) begin
            bus.dr_ld  = 1'b1;
            bus.pc_inc = 1'b1;
            bus.ar_inc = 1'b1;
            state_d    = (state_q == LDAC1) ? LDAC2 : STAC2;
          end
        end
        LDAC2, STAC2: begin
          bus.mem_rd = 1'b1;
          if (bus.mem_ready) begin
            bus.tr_ld  = 1'b1;
            bus.dr_ld  = 1'b1;
            bus.pc_inc = 1'b1;
            state_d    = (state_q == LDAC2) ? LDAC3 : STAC3;
          end
        end
        LDAC3, STAC3: begin
          bus.ar_ld  = 1'b1;
          bus.ar_sel = 1'b1;
          state_d    = (state_q == LDAC3) ? LDAC4 : STAC4;
        end
        LDAC4: begin
          bus.mem_rd = 1'b1;
          if (bus.mem_ready) begin
            bus.dr_ld = 1'b1;
            state_d   = LDAC5;
          end
        end
        LDAC5: begin
          bus.ac_ld  = 1'b1;
          bus.ac_sel = AC_SRC_DR;
          state_d    = FETCH1;
        end
        STAC4: begin
          bus.dr_ld  = 1'b1;
          bus.dr_sel = 1'b1;
          state_d    = STAC5;
        end
        STAC5: begin
          bus.mem_wr = 1'b1;
          if (bus.mem_ready) state_d = FETCH1;
        end
        MVAC1: begin
          bus.r_ld = 1'b1;
          state_d  = FETCH1;
        end
        MOVR1: begin
          bus.ac_ld  = 1'b1;
          bus.ac_sel = AC_SRC_R;
          state_d    = FETCH1;
        end
        JUMP1: begin
          bus.mem_rd = 1'b1;
          if (bus.mem_ready) begin
            bus.dr_ld  = 1'b1;
            bus.ar_inc = 1'b1;
            state_d    = JUMP2;
          end
        end
        JUMP2: begin
          bus.mem_rd = 1'b1;
          if (bus.mem_ready) begin
            bus.tr_ld = 1'b1;
            bus.dr_ld = 1'b1;
            state_d   = JUMP3;
          end
        end
        JUMP3: begin
          bus.pc_ld = 1'b1;
          state_d   = FETCH1;
        end
        ALU1: begin
          bus.ac_ld   = 1'b1;
          bus.ac_sel  = AC_SRC_ALU;
          bus.z_ld    = 1'b1;
          bus.alu_sel = bus.ir[2:0];
          state_d     = FETCH1;
        end
        SKIP1: begin
          bus.pc_inc = 1'b1;
          state_d    = SKIP2;
        end
        SKIP2: begin
          bus.pc_inc = 1'b1;
          state_d    = FETCH1;
        end
        HALT: begin
          bus.mem_err = 1'b1;
        end
        default: state_d = FETCH1;
      endcase

      // Expiry only occurs while stalled, so no strobe of the abandoned state has fired.
      if (tmo_expired) state_d = HALT;
    end
  end

endmodule

// File: tb/tb_rscpu_control_unit.sv
module tb_rscpu_control_unit;

  localparam int unsigned TMO = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  rscpu_control_unit_if bus();

  rscpu_control_unit #(.MEM_TIMEOUT(TMO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Observed output vector, MSB first.
  wire [19:0] obs = {bus.ar_ld, bus.ar_inc, bus.pc_ld, bus.pc_inc, bus.dr_ld, bus.tr_ld,
                     bus.ir_ld, bus.r_ld, bus.ac_ld, bus.z_ld, bus.ar_sel, bus.dr_sel,
                     bus.ac_sel, bus.alu_sel, bus.mem_rd, bus.mem_wr, bus.mem_err};

  localparam logic [19:0] AR_LD   = 20'h80000;
  localparam logic [19:0] AR_INC  = 20'h40000;
  localparam logic [19:0] PC_LD   = 20'h20000;
  localparam logic [19:0] PC_INC  = 20'h10000;
  localparam logic [19:0] DR_LD   = 20'h08000;
  localparam logic [19:0] TR_LD   = 20'h04000;
  localparam logic [19:0] IR_LD   = 20'h02000;
  localparam logic [19:0] R_LD    = 20'h01000;
  localparam logic [19:0] AC_LD   = 20'h00800;
  localparam logic [19:0] Z_LD    = 20'h00400;
  localparam logic [19:0] AR_SEL  = 20'h00200;
  localparam logic [19:0] DR_SEL  = 20'h00100;
  localparam logic [19:0] AC_ALU  = 20'h00080;
  localparam logic [19:0] AC_R    = 20'h00040;
  localparam logic [19:0] MEM_RD  = 20'h00004;
  localparam logic [19:0] MEM_WR  = 20'h00002;
  localparam logic [19:0] MEM_ERR = 20'h00001;

  logic [19:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_halts = 0;

  // Micro-steps of the current instruction: kind 0 = internal, 1 = memory read, 2 = memory write.
  int          st_kind[$];
  logic [19:0] st_out[$];

  function automatic logic [19:0] alu_field(input logic [7:0] i);
    logic [19:0] v;
    v = '0;
    v[5:3] = i[2:0];
    return v;
  endfunction

  task automatic st(input int k, input logic [19:0] o);
    st_kind.push_back(k);
    st_out.push_back(o);
  endtask

  // Register-transfer list of one instruction, straight from the ISA description.
  task automatic build(input logic [7:0] i, input logic zz);
    logic taken;
    st_kind.delete();
    st_out.delete();
    st(0, AR_LD);                       // AR <- PC
    st(1, DR_LD | PC_INC);              // DR <- M, PC++
    st(0, IR_LD | AR_LD);               // IR <- DR, AR <- PC
    if (i[7:4] != 4'h0) begin
      st(0, '0);
    end else if (i[3]) begin
      st(0, AC_LD | AC_ALU | Z_LD | alu_field(i));
    end else begin
      case (i[2:0])
        3'd1, 3'd2: begin
          st(1, DR_LD | PC_INC | AR_INC);
          st(1, TR_LD | DR_LD | PC_INC);
          st(0, AR_LD | AR_SEL);
          if (i[2:0] == 3'd1) begin
            st(1, DR_LD);
            st(0, AC_LD);
          end else begin
            st(0, DR_LD | DR_SEL);
            st(2, '0);
          end
        end
        3'd3: st(0, R_LD);
        3'd4: st(0, AC_LD | AC_R);
        3'd5, 3'd6, 3'd7: begin
          taken = (i[2:0] == 3'd5) || (i[2:0] == 3'd6 && zz) || (i[2:0] == 3'd7 && !zz);
          if (taken) begin
            st(1, DR_LD | AR_INC);
            st(1, TR_LD | DR_LD);
            st(0, PC_LD);
          end else begin
            st(0, PC_INC);
            st(0, PC_INC);
          end
        end
        default: st(0, '0);
      endcase
    end
  endtask

  task automatic cycle(input logic r, input logic [7:0] i, input logic zz,
                       input logic rdy, input logic [19:0] e);
    @(posedge clk);
    #1;
    reset         = r;
    bus.ir        = i;
    bus.z         = zz;
    bus.mem_ready = rdy;
    exp_q.push_back(e);
  endtask

  task automatic reset_cycles(input int n);
    repeat (n) cycle(1'b1, bus.ir, 1'($urandom), 1'($urandom), '0);
  endtask

  // fwait >= 0 forces that many stall cycles on every memory step; abort_at injects reset.
  task automatic run_instr(input logic [7:0] i, input logic zz, input int fwait, input int abort_at);
    int w;
    logic zc;
    logic [19:0] mb;
    build(i, zz);
    for (int s = 0; s < st_kind.size(); s++) begin
      if (s == abort_at) begin
        reset_cycles(2);
        return;
      end
      zc = (s == 2) ? zz : 1'($urandom);
      if (st_kind[s] == 0) begin
        cycle(1'b0, i, zc, 1'($urandom), st_out[s]);
      end else begin
        mb = (st_kind[s] == 1) ? MEM_RD : MEM_WR;
        if (fwait >= 0) w = fwait;
        else if ($urandom_range(0, 24) == 0) w = TMO;
        else w = $urandom_range(0, TMO - 1);
        if (w >= TMO) begin
          repeat (TMO) cycle(1'b0, i, zc, 1'b0, mb);
          repeat (3) cycle(1'b0, i, 1'($urandom), 1'($urandom), MEM_ERR);
          reset_cycles(2);
          n_halts++;
          return;
        end
        repeat (w) cycle(1'b0, i, zc, 1'b0, mb);
        cycle(1'b0, i, zc, 1'b1, st_out[s] | mb);
      end
    end
  endtask

  // Monitor: the control unit presents a response every cycle; compare mid-cycle.
  initial begin
    int cyc;
    logic [19:0] e;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL outputs cycle %0d ir=%h: got %b required %b", cyc, bus.ir, obs, e);
        end
        cyc++;
      end
    end
  end

  initial begin
    logic [7:0] i;
    int ab;
    bus.ir        = 8'h00;
    bus.z         = 1'b0;
    bus.mem_ready = 1'b0;

    reset_cycles(3);
    run_instr(8'h08, 1'b0, 0, -1);   // ADD, zero wait
    run_instr(8'h0F, 1'b1, 0, -1);   // ALU op with alu_sel 111
    run_instr(8'h01, 1'b0, 0, -1);   // LDAC
    run_instr(8'h02, 1'b1, 0, -1);   // STAC
    run_instr(8'h06, 1'b0, 0, -1);   // JMPZ not taken
    run_instr(8'h06, 1'b1, 0, -1);   // JMPZ taken
    run_instr(8'h07, 1'b0, 0, -1);   // JPNZ taken
    run_instr(8'h07, 1'b1, 0, -1);   // JPNZ not taken
    run_instr(8'h03, 1'b0, 0, -1);   // MVAC
    run_instr(8'h04, 1'b0, 0, -1);   // MOVR
    run_instr(8'h05, 1'b0, 0, -1);   // JUMP
    run_instr(8'h35, 1'b0, 0, -1);   // upper nibble set decodes as NOP
    run_instr(8'h00, 1'b0, 3, -1);   // FETCH2 stalled 3 cycles
    run_instr(8'h01, 1'b0, TMO - 1, -1); // ready on the limit cycle wins
    run_instr(8'h00, 1'b0, TMO, -1); // stuck memory -> HALT until reset
    run_instr(8'h02, 1'b0, 0, 6);    // reset while in STAC4
    run_instr(8'h00, 1'b0, 0, -1);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) i = 8'($urandom);
      else i = {4'h0, 4'($urandom)};
      ab = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 8) : -1;
      run_instr(i, 1'($urandom), -1, ab);
    end

    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
